load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns pipeline requests onto a lane-based
// memory port, flags misaligned/illegal accesses, and extends load results.
module load_store_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [TAG_W-1:0]    resp_tag,
  output logic                resp_err,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              r_state;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [OFF_W-1:0]    r_off;
  logic [TAG_W-1:0]    r_tag;
  logic                r_mem_valid;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [BE_W-1:0]     r_mem_be;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic [TAG_W-1:0]    r_resp_tag;
  logic                r_resp_err;

  logic [OFF_W-1:0]    w_off;
  logic [3:0]          w_bytes;
  logic [OFF_W-1:0]    w_align_mask;
  logic                w_misaligned;
  logic                w_illegal;
  logic [BE_W-1:0]     w_be_base;
  logic [BE_W-1:0]     w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_shifted;
  logic [7:0]          w_nbits;
  logic [DATA_W-1:0]   w_lmask;
  logic                w_sign;
  logic                w_ext;
  logic [DATA_W-1:0]   w_load;

  // Request-side decode, evaluated on the live request and captured at acceptance.
  always_comb begin
    w_off        = req_addr[OFF_W-1:0];
    w_bytes      = 4'd1 << req_size;
    w_align_mask = OFF_W'(w_bytes - 4'd1);
    w_misaligned = (w_off & w_align_mask) != '0;
    w_illegal    = (req_size == 2'b11) && (DATA_W == 32);
    w_addr       = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    w_be_base    = {BE_W{1'b1}};
    w_wdata      = req_wdata;
    case (req_size)
      2'b00: begin
        w_be_base = BE_W'(1'b1);
        w_wdata   = {BE_W{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be_base = BE_W'(2'b11);
        w_wdata   = {(DATA_W/16){req_wdata[15:0]}};
      end
      2'b10: begin
        w_be_base = BE_W'(4'hF);
        w_wdata   = {(DATA_W/32){req_wdata[31:0]}};
      end
      default: ;
    endcase
    w_be = req_we ? (w_be_base << w_off) : '0;
  end

  // Load-lane extraction; a shift by the full width yields an all-ones mask.
  always_comb begin
    w_shifted = mem_rdata >> {r_off, 3'b000};
    w_nbits   = 8'd8 << r_size;
    w_lmask   = ~({DATA_W{1'b1}} << w_nbits);
    case (r_size)
      2'b00:   w_sign = w_shifted[7];
      2'b01:   w_sign = w_shifted[15];
      2'b10:   w_sign = w_shifted[31];
      default: w_sign = w_shifted[DATA_W-1];
    endcase
    w_ext  = !r_unsigned && w_sign && (r_size != 2'b11);
    w_load = (w_shifted & w_lmask) | (w_ext ? ~w_lmask : '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_off        <= '0;
      r_tag        <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_off      <= w_off;
            r_tag      <= req_tag;
            if (w_illegal || w_misaligned) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= '0;
              r_resp_tag   <= req_tag;
            end else begin
              r_state     <= ISSUE;
              r_mem_valid <= 1'b1;
              r_mem_we    <= req_we;
              r_mem_addr  <= w_addr;
              r_mem_be    <= w_be;
              r_mem_wdata <= req_we ? w_wdata : '0;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            if (r_we) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_data  <= '0;
              r_resp_tag   <= r_tag;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_data  <= w_load;
            r_resp_tag   <= r_tag;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_data  <= '0;
          r_resp_tag   <= '0;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign mem_valid  = r_mem_valid;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_tag   = r_resp_tag;
  assign resp_err   = r_resp_err;

endmodule
